// File: rtl/sram_access_seq_pkg.sv
// rtl/sram_access_seq_pkg.sv - shared types, timing defaults and parity helper for the SRAM access sequencer
// Optional feature macro: SRAM_ACCESS_SEQ_PARITY_EN (adds one parity bit to the array data buses)
package sram_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WRITE,
    SENSE,
    DONE
  } seq_state_e;

  localparam int SEQ_PRE_CYCLES_DEF   = 1;
  localparam int SEQ_WR_CYCLES_DEF    = 2;
  localparam int SEQ_SENSE_CYCLES_DEF = 1;

`ifdef SRAM_ACCESS_SEQ_PARITY_EN
  localparam int SEQ_PAR_BITS = 1;
`else
  localparam int SEQ_PAR_BITS = 0;
`endif

  // Words up to this width can be reduced; callers zero-extend, which leaves parity unchanged.
  localparam int SEQ_PAR_MAX_W = 256;

  function automatic logic parity_even(input logic [SEQ_PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sram_access_seq_if.sv
// rtl/sram_access_seq_if.sv - host-side request/response bus of the SRAM access sequencer
interface sram_access_seq_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  cs_n;
  logic                  we_n;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output cs_n, we_n, addr, wdata,
    input  busy, ready, rdata
  );

  modport slave (
    input  cs_n, we_n, addr, wdata,
    output busy, ready, rdata
  );
endinterface

// File: rtl/sram_phase_timer.sv
// rtl/sram_phase_timer.sv - loadable down-counter shared by all sequencer phases
module sram_phase_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);
  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);
endmodule

// File: rtl/sram_access_seq.sv
// rtl/sram_access_seq.sv - SRAM phase sequencer: precharge, word-line with write drive or sense, done
// Optional feature macro: SRAM_ACCESS_SEQ_PARITY_EN (parity bit on array buses plus par_err output)
module sram_access_seq
  import sram_seq_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int PRE_CYCLES   = SEQ_PRE_CYCLES_DEF,
  parameter int WR_CYCLES    = SEQ_WR_CYCLES_DEF,
  parameter int SENSE_CYCLES = SEQ_SENSE_CYCLES_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  sram_access_seq_if.slave                   host,
  output logic [ADDR_WIDTH-1:0]              arr_addr,
  output logic [DATA_WIDTH+SEQ_PAR_BITS-1:0] arr_wdata,
  input  logic [DATA_WIDTH+SEQ_PAR_BITS-1:0] arr_rdata,
`ifdef SRAM_ACCESS_SEQ_PARITY_EN
  output logic                               par_err,
`endif
  output logic                               precharge,
  output logic                               wl_en,
  output logic                               write_en,
  output logic                               sense_en
);
  localparam int ARR_W   = DATA_WIDTH + SEQ_PAR_BITS;
  localparam int MAX_A   = (PRE_CYCLES > WR_CYCLES) ? PRE_CYCLES : WR_CYCLES;
  localparam int MAX_CYC = (MAX_A > SENSE_CYCLES) ? MAX_A : SENSE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] PRE_LD   = CW'(PRE_CYCLES - 1);
  localparam logic [CW-1:0] WR_LD    = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] SENSE_LD = CW'(SENSE_CYCLES - 1);

  if (PRE_CYCLES < 1) begin : g_bad_pre
    $error("PRE_CYCLES must be >= 1");
  end
  if (WR_CYCLES < 1) begin : g_bad_wr
    $error("WR_CYCLES must be >= 1");
  end
  if (SENSE_CYCLES < 1) begin : g_bad_sense
    $error("SENSE_CYCLES must be >= 1");
  end

  seq_state_e            state_q;
  logic                  op_wr_q;
  logic                  busy_q;
  logic                  ready_q;
  logic                  precharge_q;
  logic                  wl_en_q;
  logic                  write_en_q;
  logic                  sense_en_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] arr_addr_q;
  logic [ARR_W-1:0]      arr_wdata_q;
`ifdef SRAM_ACCESS_SEQ_PARITY_EN
  logic                  par_err_q;
`endif

  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic [CW-1:0] tmr_cnt;
  logic          tmr_zero;

  // Timer loads happen on phase entry so the count is valid in the first cycle of the new phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (!host.cs_n) begin
          tmr_load = 1'b1;
          tmr_val  = PRE_LD;
        end
      end
      PRE: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = op_wr_q ? WR_LD : SENSE_LD;
        end
      end
      default: ;
    endcase
  end

  sram_phase_timer #(.WIDTH(CW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .count_o    (tmr_cnt),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_wr_q     <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      precharge_q <= 1'b0;
      wl_en_q     <= 1'b0;
      write_en_q  <= 1'b0;
      sense_en_q  <= 1'b0;
      rdata_q     <= '0;
      arr_addr_q  <= '0;
      arr_wdata_q <= '0;
`ifdef SRAM_ACCESS_SEQ_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!host.cs_n) begin
            arr_addr_q  <= host.addr;
`ifdef SRAM_ACCESS_SEQ_PARITY_EN
            arr_wdata_q <= {parity_even(SEQ_PAR_MAX_W'(host.wdata)), host.wdata};
`else
            arr_wdata_q <= host.wdata;
`endif
            op_wr_q     <= !host.we_n;
            busy_q      <= 1'b1;
            precharge_q <= 1'b1;
            state_q     <= PRE;
          end
        end
        PRE: begin
          if (tmr_zero) begin
            precharge_q <= 1'b0;
            wl_en_q     <= 1'b1;
            if (op_wr_q) begin
              write_en_q <= 1'b1;
              state_q    <= WRITE;
            end else begin
              sense_en_q <= (SENSE_CYCLES == 1);
              state_q    <= SENSE;
            end
          end
        end
        WRITE: begin
          if (tmr_zero) begin
            wl_en_q    <= 1'b0;
            write_en_q <= 1'b0;
            ready_q    <= 1'b1;
            state_q    <= DONE;
          end
        end
        SENSE: begin
          if (tmr_zero) begin
            wl_en_q    <= 1'b0;
            sense_en_q <= 1'b0;
            rdata_q    <= arr_rdata[DATA_WIDTH-1:0];
`ifdef SRAM_ACCESS_SEQ_PARITY_EN
            par_err_q  <= parity_even(SEQ_PAR_MAX_W'(arr_rdata));
`endif
            ready_q    <= 1'b1;
            state_q    <= DONE;
          end else begin
            // Raise sense_en so it lands on the final word-line cycle.
            sense_en_q <= (tmr_cnt == CW'(1));
          end
        end
        DONE: begin
          ready_q   <= 1'b0;
          busy_q    <= 1'b0;
`ifdef SRAM_ACCESS_SEQ_PARITY_EN
          par_err_q <= 1'b0;
`endif
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign host.busy  = busy_q;
  assign host.ready = ready_q;
  assign host.rdata = rdata_q;
  assign arr_addr   = arr_addr_q;
  assign arr_wdata  = arr_wdata_q;
  assign precharge  = precharge_q;
  assign wl_en      = wl_en_q;
  assign write_en   = write_en_q;
  assign sense_en   = sense_en_q;
`ifdef SRAM_ACCESS_SEQ_PARITY_EN
  assign par_err    = par_err_q;
`endif
endmodule

// File: doc/sram_access_seq.md
Name: sram_access_seq

Overview:
- Control sequencer directly upstream of the SRAM memory array.
- Accepts one chip-select request at a time from the host bus (cs_n/we_n/addr/wdata).
- Drives the array's phase controls in order: precharge, then word-line plus write drive or sense, then done.
- Captures read data from the sense path and returns it with a one-cycle ready pulse.

Parameters:
- ADDR_WIDTH, 8, array address width.
- DATA_WIDTH, 32, data word width.
- PRE_CYCLES, 1, precharge phase length in cycles; must be >= 1.
- WR_CYCLES, 2, word-line plus write-drive phase length; must be >= 1.
- SENSE_CYCLES, 1, word-line phase length for reads; sense_en is asserted on its last cycle; must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cs_n  in  1  request strobe, active low; sampled only in IDLE.
- we_n  in  1  0 = write, 1 = read; sampled with cs_n.
- addr  in  ADDR_WIDTH  request address.
- wdata  in  DATA_WIDTH  write data.
- busy  out  1  high in every state except IDLE.
- ready  out  1  one-cycle completion pulse.
- rdata  out  DATA_WIDTH  last read result; held until the next read completes.
- arr_addr  out  ADDR_WIDTH  latched address to the decoder.
- arr_wdata  out  DATA_WIDTH(+1)  latched write data to the write driver.
- arr_rdata  in  DATA_WIDTH(+1)  sense-amp output.
- precharge  out  1  bit-line precharge enable.
- wl_en  out  1  word-line enable.
- write_en  out  1  write-driver enable.
- sense_en  out  1  sense-amp enable.

Behaviour:
- Reset (rst=1 at clk edge):
  - state goes to IDLE.
  - busy, ready, precharge, wl_en, write_en, sense_en go to 0.
  - rdata, arr_addr, arr_wdata go to 0.
  - A reset in mid-operation aborts the operation: no ready pulse, and rdata is not updated.
- States are IDLE, PRE, WRITE, SENSE, DONE. All outputs are registered.
- IDLE:
  - If cs_n=0 at the edge, latch addr, wdata and we_n into arr_addr, arr_wdata and op, then go to PRE.
  - If cs_n=1, stay in IDLE.
- PRE:
  - precharge=1 for PRE_CYCLES cycles.
  - Then go to WRITE if op is write, otherwise SENSE.
- WRITE:
  - wl_en=1 and write_en=1 for WR_CYCLES cycles, then go to DONE.
- SENSE:
  - wl_en=1 for SENSE_CYCLES cycles.
  - sense_en=1 on the final SENSE cycle only.
  - At the end of that cycle, arr_rdata[DATA_WIDTH-1:0] is captured into rdata, then go to DONE.
- DONE:
  - ready=1 and busy=1 for exactly one cycle, then go to IDLE.
  - For a read, rdata is already valid in the DONE cycle.
- Latency from the accepting edge to ready high:
  - Write: PRE_CYCLES+WR_CYCLES+1 cycles (4 with defaults).
  - Read: PRE_CYCLES+SENSE_CYCLES+1 cycles (3 with defaults).
- Invariants:
  - precharge never overlaps wl_en.
  - write_en and sense_en are never both high.
  - write_en and sense_en are only high while wl_en=1.
  - arr_addr and arr_wdata are stable from PRE through DONE.
- Back-to-back requests:
  - cs_n is ignored in PRE, WRITE, SENSE and DONE; requests are not queued.
  - The earliest next accept is the edge that ends the first IDLE cycle after DONE.
  - A held cs_n=0 therefore issues one operation per PRE+phase+2 cycles.
- Phase counters:
  - Down-counters loaded with N-1 on phase entry; the phase exits when the counter is 0.
  - Width is $clog2(max(PRE_CYCLES, WR_CYCLES, SENSE_CYCLES)+1).
- Parameters below 1 cause an elaboration error ($error in an initial/generate check).

Optional Feature:
- Macro: SRAM_ACCESS_SEQ_PARITY_EN.
- When defined:
  - arr_wdata and arr_rdata are DATA_WIDTH+1 bits wide.
  - Bit DATA_WIDTH carries even parity (XOR-reduce) of the latched wdata.
  - On a read, parity is checked on the captured word.
  - A new output par_err (1 bit) pulses high together with ready when the check fails.
  - rdata is still updated on a parity failure.
  - par_err resets to 0.
- When undefined: both array buses are DATA_WIDTH wide, par_err does not exist, and no check is performed.

Decomposition:
- Package sram_seq_pkg holds:
  - the state enum seq_state_e {IDLE, PRE, WRITE, SENSE, DONE};
  - default timing constants SEQ_PRE_CYCLES_DEF, SEQ_WR_CYCLES_DEF, SEQ_SENSE_CYCLES_DEF;
  - a function parity_even().
- Sub-module sram_phase_timer: loadable down-counter with load, count-value input and a zero flag. The top instantiates it once and reuses it across phases.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, cs_n=1 -> all outputs 0, busy=0, rdata=0.
2. Write at defaults: cs_n=0 with addr=0x3C, wdata=0xDEADBEEF, we_n=0 -> precharge in cycle 1, wl_en and write_en in cycles 2-3, ready in cycle 4, arr_wdata=0xDEADBEEF throughout.
3. Read at defaults: cs_n=0, we_n=1, addr=0x3C, model drives arr_rdata=0xDEADBEEF -> precharge in cycle 1, wl_en and sense_en in cycle 2, ready with rdata=0xDEADBEEF in cycle 3.
4. Held cs_n=0 for 20 cycles (reads) -> ready pulses exactly every 4 cycles; no phase overlap is asserted.
5. Reset mid-operation: rst=1 during a WRITE cycle of a write to 0x10 -> all enables low next cycle, no ready, state IDLE; a following read returns the model data.
6. SRAM_ACCESS_SEQ_PARITY_EN: model flips arr_rdata bit 5 on read of 0x0000000F -> par_err=1 with ready, rdata=0x0000002F.
